// File: rtl/irq_ctrl_pkg.sv
// Shared FSM state type and register offsets for the interrupt controller.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [3:0] OFF_PENDING = 4'h0;
  localparam logic [3:0] OFF_ENABLE  = 4'h4;
  localparam logic [3:0] OFF_CLAIM   = 4'h8;
  localparam logic [3:0] OFF_EOI     = 4'hC;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder over up to 31 request lines.
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         vld,
  output logic [4:0]   id
);

  always_comb begin
    vld = |req;
    id  = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = 5'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with PENDING/ENABLE/CLAIM/EOI registers.
// Define IRQ_CTRL_LEVEL_EN to make sources level-sensitive instead.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  output logic             I_Req,
  input  logic             IACK,
  input  logic [31:0]      Data_addr,
  input  logic [31:0]      Wdata,
  input  logic [3:0]       we,
  output logic [31:0]      Rdata
);

  logic             sel;
  logic             wr;
  logic [3:0]       off;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] set_mask;
  logic [N_SRC-1:0] w1c_mask;
  logic [N_SRC-1:0] ack_mask;
  logic             prio_vld;
  logic [4:0]       prio_id;
  logic [4:0]       cur_id;
  state_t           state;
  logic             unused_wdata;

  assign sel          = (Data_addr[31:4] == BASE_ADDR[31:4]);
  assign wr           = sel && (we != 4'b0000);
  assign off          = Data_addr[3:0];
  assign unused_wdata = ^Wdata;

`ifdef IRQ_CTRL_LEVEL_EN
  assign set_mask = src;
`else
  logic [N_SRC-1:0] src_q;

  always_ff @(posedge clk) begin
    if (reset) src_q <= '0;
    else       src_q <= src;
  end

  assign set_mask = src & ~src_q;
`endif

  assign w1c_mask = (wr && off == OFF_PENDING) ? Wdata[N_SRC-1:0] : '0;
  assign ack_mask = (state == REQ && IACK) ? (N_SRC'(1) << cur_id) : '0;

  irq_prio_enc #(.N(N_SRC)) u_prio_enc (
    .req (pending & enable),
    .vld (prio_vld),
    .id  (prio_id)
  );

  // New source activity is OR-ed in last so it survives a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      enable  <= '0;
    end else begin
      pending <= (pending & ~(w1c_mask | ack_mask)) | set_mask;
      if (wr && off == OFF_ENABLE) enable <= Wdata[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cur_id <= '0;
      I_Req  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (prio_vld) begin
            cur_id <= prio_id;
            state  <= REQ;
            I_Req  <= 1'b1;
          end
        end
        REQ: begin
          if (IACK) begin
            state <= SERVICE;
            I_Req <= 1'b0;
          end
        end
        SERVICE: begin
          if (wr && off == OFF_EOI) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          I_Req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Rdata = '0;
    if (sel) begin
      case (off)
        OFF_PENDING: Rdata = 32'(pending);
        OFF_ENABLE:  Rdata = 32'(enable);
        OFF_CLAIM:   Rdata = {(state == SERVICE), 26'b0, cur_id};
        default:     Rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed scoreboard bench: stimulus queues expected read/I_Req values, a monitor compares on negedge.
module tb_irq_controller;

  localparam logic [31:0] A_PEND  = 32'h0000_1000;
  localparam logic [31:0] A_EN    = 32'h0000_1004;
  localparam logic [31:0] A_CLAIM = 32'h0000_1008;
  localparam logic [31:0] A_EOI   = 32'h0000_100C;
  localparam logic [31:0] A_OTHER = 32'h0000_2004;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic        I_Req;
  logic        IACK;
  logic [31:0] Data_addr;
  logic [31:0] Wdata;
  logic [3:0]  we;
  logic [31:0] Rdata;

  int passed = 0;
  int total  = 0;

  logic [31:0] q_rd[$];
  bit          q_ci[$];
  bit          q_irq[$];
  string       q_nm[$];

  always #5 clk = ~clk;

  irq_controller #(.N_SRC(8), .BASE_ADDR(32'h0000_1000)) dut (
    .clk       (clk),
    .reset     (reset),
    .src       (src),
    .I_Req     (I_Req),
    .IACK      (IACK),
    .Data_addr (Data_addr),
    .Wdata     (Wdata),
    .we        (we),
    .Rdata     (Rdata)
  );

  // Monitor: pops one expectation per presented read and compares.
  initial begin
    forever begin
      @(negedge clk);
      if (q_rd.size() > 0) begin
        logic [31:0] e_rd;
        bit          e_ci;
        bit          e_irq;
        string       nm;
        e_rd  = q_rd.pop_front();
        e_ci  = q_ci.pop_front();
        e_irq = q_irq.pop_front();
        nm    = q_nm.pop_front();
        total++;
        if (Rdata === e_rd) passed++;
        else $display("FAIL %s rdata: got %08h expected %08h", nm, Rdata, e_rd);
        if (e_ci) begin
          total++;
          if (I_Req === e_irq) passed++;
          else $display("FAIL %s i_req: got %b expected %b", nm, I_Req, e_irq);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Data_addr = a;
    Wdata     = d;
    we        = 4'hF;
    step();
    we        = 4'h0;
  endtask

  // Issues one read for one cycle; the check covers state before this cycle's edge.
  task automatic chk(input logic [31:0] a, input logic [31:0] e, input bit ci,
                     input bit ei, input string nm);
    Data_addr = a;
    we        = 4'h0;
    q_rd.push_back(e);
    q_ci.push_back(ci);
    q_irq.push_back(ei);
    q_nm.push_back(nm);
    @(negedge clk);
    #1;
    if (q_rd.size() != 0) begin
      $display("FAIL %s: monitor did not consume expectation (pending %0d)", nm, q_rd.size());
      total++;
      q_rd.delete();
      q_ci.delete();
      q_irq.delete();
      q_nm.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; src = '0; IACK = 1'b0; Data_addr = '0; Wdata = '0; we = '0;
    repeat (3) step();
    reset = 1'b0;

    chk(A_PEND,  32'h0, 1, 0, "reset_pending");
    chk(A_EN,    32'h0, 1, 0, "reset_enable");
    chk(A_CLAIM, 32'h0, 1, 0, "reset_claim");

    // Single source: pending after the sampling edge, I_Req one edge later.
    wr(A_EN, 32'h01);
    chk(A_EN, 32'h01, 1, 0, "en_write");
    src = 8'h01; step(); src = 8'h00;
    chk(A_PEND,  32'h01, 1, 0, "lat_pending");
    chk(A_PEND,  32'h01, 1, 1, "lat_ireq");
    IACK = 1'b1; step(); IACK = 1'b0;
    chk(A_CLAIM, 32'h8000_0000, 1, 0, "iack_claim");
    chk(A_PEND,  32'h00, 1, 0, "iack_pending");
    wr(A_EOI, 32'h0);
    chk(A_CLAIM, 32'h0, 1, 0, "eoi_claim");

    // Two simultaneous sources: lowest index first, the other after EOI.
    wr(A_EN, 32'hFF);
    src = 8'h48; step(); src = 8'h00;
    step();
    chk(A_CLAIM, 32'h3, 1, 1, "prio_first");
    IACK = 1'b1; step(); IACK = 1'b0;
    chk(A_CLAIM, 32'h8000_0003, 1, 0, "prio_svc3");
    chk(A_PEND,  32'h40, 1, 0, "prio_left");
    wr(A_EOI, 32'h0);
    chk(A_CLAIM, 32'h3, 1, 0, "prio_idle");
    chk(A_CLAIM, 32'h6, 1, 1, "prio_second");
    IACK = 1'b1; step(); IACK = 1'b0;
    wr(A_EOI, 32'h0);

    // Set beats a same-cycle W1C; a plain W1C clears.
    wr(A_EN, 32'h00);
    src = 8'h04;
    wr(A_PEND, 32'h04);
    src = 8'h00;
    chk(A_PEND, 32'h04, 1, 0, "set_wins");
    wr(A_PEND, 32'h04);
    chk(A_PEND, 32'h00, 1, 0, "w1c_clear");

    // EOI in IDLE is ignored; ENABLE reads back immediately; other addresses are inert.
    wr(A_EOI, 32'h0);
    chk(A_CLAIM, 32'h6, 1, 0, "eoi_idle");
    wr(A_EN, 32'hA5);
    chk(A_EN, 32'hA5, 1, 0, "en_readback");
    wr(A_OTHER, 32'hFF);
    chk(A_EN,    32'hA5, 1, 0, "unsel_write");
    chk(A_OTHER, 32'h0,  1, 0, "unsel_read");
    wr(A_EN, 32'h00);

    // Held source then W1C: level mode re-sets, edge mode stays cleared.
    src = 8'h02; step();
    wr(A_PEND, 32'h02);
`ifdef IRQ_CTRL_LEVEL_EN
    chk(A_PEND, 32'h02, 1, 0, "held_w1c");
`else
    chk(A_PEND, 32'h00, 1, 0, "held_w1c");
`endif
    src = 8'h00;
    wr(A_PEND, 32'h02);
    chk(A_PEND, 32'h00, 1, 0, "held_clear");

    // Re-trigger of cur_id during SERVICE is serviced after EOI.
    wr(A_EN, 32'h01);
    src = 8'h01; step(); src = 8'h00;
    step();
    IACK = 1'b1; step(); IACK = 1'b0;
    src = 8'h01; step(); src = 8'h00;
    chk(A_PEND,  32'h01,        1, 0, "svc_repend");
    chk(A_CLAIM, 32'h8000_0000, 1, 0, "svc_hold");
    wr(A_EOI, 32'h0);
    step();
    chk(A_CLAIM, 32'h0, 1, 1, "svc_rereq");
    IACK = 1'b1; step(); IACK = 1'b0;
    wr(A_EOI, 32'h0);

    // Reset while requesting.
    src = 8'h01; step(); src = 8'h00;
    step();
    chk(A_PEND, 32'h01, 1, 1, "pre_reset");
    reset = 1'b1; step(); reset = 1'b0;
    chk(A_PEND,  32'h0, 1, 0, "rst_pending");
    chk(A_EN,    32'h0, 1, 0, "rst_enable");
    chk(A_CLAIM, 32'h0, 1, 0, "rst_claim");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter N_SRC, default 8, SHALL set the number of interrupt sources (1..31).
REQ-003 Parameter BASE_ADDR, default 32'h0000_1000, SHALL set the register block base; bits [3:0] are ignored.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 src  input  N_SRC  interrupt source lines, synchronous to clk.
REQ-007 I_Req  output  1  interrupt request to core.
REQ-008 IACK  input  1  interrupt acknowledge from core.
REQ-009 Data_addr  input  32  data-bus address from core.
REQ-010 Wdata  input  32  data-bus write data.
REQ-011 we  input  4  data-bus byte write enables; any nonzero bit counts as a write.
REQ-012 Rdata  output  32  data-bus read data.

Function
REQ-013 The block SHALL be selected when Data_addr[31:4] == BASE_ADDR[31:4]; when not selected, Rdata SHALL be 0 and writes are ignored.
REQ-014 Register map SHALL be: 0x0 PENDING (read; write-1-to-clear), 0x4 ENABLE (read/write), 0x8 CLAIM (read-only: bit31 = in-service, bits[4:0] = id), 0xC EOI (any write completes service; reads return 0).
REQ-015 Rdata SHALL be combinational from Data_addr with zero latency; unused upper bits read 0.
REQ-016 Without IRQ_CTRL_LEVEL_EN, a source SHALL set its pending bit on the clock edge where src[i]=1 and its registered previous value src_q[i]=0.
REQ-017 If a set and a W1C clear of the same pending bit occur in the same cycle, set SHALL win.
REQ-018 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-019 IDLE: if (PENDING & ENABLE) != 0, the FSM SHALL latch the lowest-index active bit as cur_id and go to REQ on that edge.
REQ-020 REQ: I_Req SHALL be 1; the FSM SHALL stay in REQ until IACK=1, even if the pending or enable bit is cleared meanwhile.
REQ-021 On an edge with REQ and IACK=1, the block SHALL clear pending[cur_id] and go to SERVICE.
REQ-022 SERVICE: I_Req SHALL be 0; an EOI write SHALL return the FSM to IDLE; an EOI write in IDLE or REQ SHALL be ignored.
REQ-023 I_Req SHALL be a registered Moore output of state REQ.
REQ-024 Latency: a source edge sampled at edge k SHALL give pending=1 after edge k and I_Req=1 after edge k+1 (when ENABLE is set and the FSM is IDLE).
REQ-025 A new edge on cur_id during SERVICE SHALL set pending again; it is serviced after EOI.
REQ-026 CLAIM.in-service SHALL be 1 only in SERVICE; CLAIM.id SHALL hold cur_id.

Reset
REQ-027 On an edge with reset=1, the FSM SHALL go to IDLE and PENDING, ENABLE, src_q, cur_id and I_Req SHALL all be 0, from any state including mid-REQ.
REQ-028 Rdata SHALL remain combinational during reset and reflect the cleared registers.

Configuration
REQ-029 With macro IRQ_CTRL_LEVEL_EN defined, pending[i] SHALL be set on every edge where src[i]=1 (level-sensitive) and src_q SHALL be omitted; when undefined, sources are rising-edge detected per REQ-016.

Structure
REQ-030 Package irq_ctrl_pkg SHALL hold the FSM state enum and the register offset constants (0x0, 0x4, 0x8, 0xC).
REQ-031 Sub-module irq_prio_enc SHALL provide a combinational lowest-index-first encoder outputting a valid bit and a 5-bit id.

Verification
REQ-032 ENABLE=0x01, src[0] rises at edge 5 -> PENDING=0x01 after edge 5; I_Req=1 after edge 6; IACK=1 at edge 9 -> I_Req=0, PENDING=0x00, CLAIM=0x8000_0000.
REQ-033 ENABLE=0xFF, src[3] and src[6] rise together -> CLAIM.id=3 first; after EOI write to 0xC, a second request is issued with CLAIM.id=6.
REQ-034 In the same cycle, a W1C write of 0x04 to 0x0 and a src[2] edge -> PENDING[2]=1.
REQ-035 Reset asserted while in REQ with I_Req=1 -> I_Req=0, PENDING=0, ENABLE=0 after that edge.
REQ-036 EOI write while IDLE -> no state change; a read at BASE_ADDR+0x4 returns ENABLE with zero latency.
REQ-037 With IRQ_CTRL_LEVEL_EN defined, src[1] held high, then W1C of 0x02 -> PENDING[1]=1 again on the next edge.
